// File: rtl/qbus_pkg.sv
// Shared types and constants for the QBUS initiator: FSM state encoding,
// idle bus value, timer sizing and the slave address map used by engines.
package qbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    SYNC,
    DSET,
    WAIT,
    REND,
    DONE
  } state_t;

  localparam logic [15:0] AD_IDLE  = 16'hFFFF;
  localparam logic [15:0] RAM_TOP  = 16'o040000;
  localparam logic [15:0] TTY_BASE = 16'o177560;

  // Width of the shared phase/timeout timer; it must reach t_tmo-1.
  function automatic int timer_width(input int t_tmo);
    return (t_tmo < 2) ? 1 : $clog2(t_tmo);
  endfunction

endpackage

// File: rtl/qbus_sync2.sv
// Two-flop synchronizer for the asynchronous RPLY line; resets to the
// inactive (high) level so a reset never looks like a reply.
module qbus_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: both stages use non-blocking assignments so each flop samples the
  // previous value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qbus_master.sv
// QBUS initiator: one DATI/DATO/DATOB cycle per host request on the
// multiplexed, inverted AD bus, with RPLY handshake and timeout.
module qbus_master
  import qbus_pkg::*;
#(
  parameter int T_ASET = 2,
  parameter int T_AHLD = 2,
  parameter int T_TMO  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        bwr,
  input  logic [15:0] adr,
  input  logic [15:0] wdat,
  output logic [15:0] rdat,
  output logic        ack,
  output logic        err,
  output logic        busy,
  input  logic [15:0] ad_in_n,
  output logic [15:0] ad_out_n,
  output logic        ad_oe,
  output logic        sync_n,
  output logic        din_n,
  output logic        dout_n,
  output logic        wtbt_n,
  input  logic        rply_n
);

  localparam int TW = timer_width(T_TMO);
  typedef logic [TW-1:0] tmr_t;

  localparam tmr_t ASET_END = tmr_t'(T_ASET - 1);
  localparam tmr_t AHLD_END = tmr_t'(T_AHLD - 1);
  localparam tmr_t TMO_END  = tmr_t'(T_TMO - 1);

  state_t      state;
  tmr_t        tmr;
  logic        l_we;
  logic        l_bwr;
  logic [15:0] l_wdat;
  logic        rply_s;
  logic        tmo_hit;

  qbus_sync2 u_rply_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rply_n),
    .q     (rply_s)
  );

  // Any phase that can wait on the slave shares one timeout; in SYNC/DSET the
  // timer keeps running past the hold time if a stale RPLY is still low.
  assign tmo_hit = (state inside {SYNC, DSET, WAIT, REND}) && (tmr == TMO_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tmr      <= '0;
      l_we     <= 1'b0;
      l_bwr    <= 1'b0;
      l_wdat   <= '0;
      rdat     <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      ad_out_n <= AD_IDLE;
      ad_oe    <= 1'b0;
      sync_n   <= 1'b1;
      din_n    <= 1'b1;
      dout_n   <= 1'b1;
      wtbt_n   <= 1'b1;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (tmo_hit) begin
        sync_n   <= 1'b1;
        din_n    <= 1'b1;
        dout_n   <= 1'b1;
        wtbt_n   <= 1'b1;
        ad_oe    <= 1'b0;
        ad_out_n <= AD_IDLE;
        ack      <= 1'b1;
        err      <= 1'b1;
        state    <= DONE;
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              l_we     <= we;
              l_bwr    <= bwr & we;
              l_wdat   <= wdat;
              busy     <= 1'b1;
              ad_oe    <= 1'b1;
              ad_out_n <= ~adr;
              wtbt_n   <= ~we;
              tmr      <= '0;
              state    <= ADDR;
            end
          end
          ADDR: begin
            if (tmr == ASET_END) begin
              tmr    <= '0;
              sync_n <= 1'b0;
              state  <= SYNC;
            end else begin
              tmr <= tmr + tmr_t'(1);
            end
          end
          SYNC: begin
            if (tmr >= AHLD_END && rply_s) begin
              tmr <= '0;
              if (l_we) begin
                ad_out_n <= ~l_wdat;
                wtbt_n   <= ~l_bwr;
                state    <= DSET;
              end else begin
                ad_oe <= 1'b0;
                din_n <= 1'b0;
                state <= WAIT;
              end
            end else begin
              tmr <= tmr + tmr_t'(1);
            end
          end
          DSET: begin
            if (tmr >= ASET_END && rply_s) begin
              tmr    <= '0;
              dout_n <= 1'b0;
              state  <= WAIT;
            end else begin
              tmr <= tmr + tmr_t'(1);
            end
          end
          WAIT: begin
            if (!rply_s) begin
              if (l_we) begin
                dout_n <= 1'b1;
              end else begin
                rdat  <= ~ad_in_n;
                din_n <= 1'b1;
              end
              tmr   <= '0;
              state <= REND;
            end else begin
              tmr <= tmr + tmr_t'(1);
            end
          end
          REND: begin
            if (rply_s) begin
              sync_n   <= 1'b1;
              ad_oe    <= 1'b0;
              ad_out_n <= AD_IDLE;
              wtbt_n   <= 1'b1;
              ack      <= 1'b1;
              state    <= DONE;
            end else begin
              tmr <= tmr + tmr_t'(1);
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
